display_frame_writer: RTL

- Capture-side write master for the display on-chip frame buffer: 16-bit, 17-bit word address, single-port, no waitrequest, write accepted in the cycle chipselect & write are high.
- Takes the camera pixel stream (one RGB565 word per valid cycle, no back-pressure) and buffers it in a small tagged FIFO.
- Writes pixels to consecutive frame-buffer addresses whenever the port arbiter grants the shared memory port.
- Reports frame completion, frame count and sticky overflow to the control processor.

---
 rtl/display_frame_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/display_frame_writer.sv
//==============================================================================
// Module  : display_frame_writer
// Purpose : Buffers a camera pixel stream and writes it into the frame buffer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module display_frame_writer #(
  parameter int FRAME_WORDS = 76800,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] c_last_addr   = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  c_frame_words = CNT_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    in_count_q, in_count_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic [DATA_W-1:0]   data_hold_q;
  logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
  logic [7:0]          frame_count_q;
  logic                overflow_q;
  logic [DATA_W:0]     mem_q [FIFO_DEPTH];

  logic                w_empty, w_full, w_pop, w_push, w_drop;
  logic                w_push_req, w_push_tag;
  logic [DATA_W:0]     w_head;
  logic [ADDR_W-1:0]   w_addr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign w_head  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign w_pop   = !w_empty && mem_grant;
  assign w_addr  = w_head[DATA_W] ? '0 : wptr_q;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  assign chipselect  = w_pop;
  assign write       = w_pop;
  assign byteenable  = w_pop ? 2'b11 : 2'b00;
  assign address     = w_pop ? w_addr : addr_hold_q;
  assign writedata   = w_pop ? w_head[DATA_W-1:0] : data_hold_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

  always_comb begin
    state_d    = state_q;
    in_count_d = in_count_q;
    w_push_req = 1'b0;
    w_push_tag = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && pix_valid && pix_sof) begin
          w_push_req = 1'b1;
          w_push_tag = 1'b1;
          in_count_d = CNT_W'(1);
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (pix_valid) begin
          w_push_req = 1'b1;
          w_push_tag = pix_sof;
          in_count_d = pix_sof ? CNT_W'(1) : in_count_q + CNT_W'(1);
          if (in_count_d == c_frame_words) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    if (w_pop) wptr_d = (w_addr == c_last_addr) ? '0 : w_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      in_count_q    <= '0;
      wptr_q        <= '0;
      addr_hold_q   <= '0;
      data_hold_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_count_q <= in_count_d;
      wptr_q     <= wptr_d;
      if (w_pop) begin
        addr_hold_q <= w_addr;
        data_hold_q <= w_head[DATA_W-1:0];
        rd_ptr_q    <= rd_ptr_q + (PTR_W+1)'(1);
      end
      if (w_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (frame_done) frame_count_q <= frame_count_q + 8'd1;
      if (w_drop) overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {w_push_tag, pix_data};
  end

endmodule

`default_nettype wire
